// File: rtl/alu_seq_muldiv_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU with
// iterative unsigned multiply/divide.
package alu_seq_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MULU = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_DIVU = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // Opcodes handled by the multi-cycle core rather than the one-cycle datapath.
  function automatic logic is_iterative(input logic [3:0] fun);
    return (fun == ALU_MULU) || (fun == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_if.sv
// Issue/result handshake bundle between the decode stage (master) and the
// execution unit (slave).
interface alu_seq_muldiv_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FUN_WIDTH  = 4
) ();

  logic                  In_Valid;
  logic                  In_Ready;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic [DATA_WIDTH-1:0] ALU_OUT;
  logic [DATA_WIDTH-1:0] ALU_OUT_HI;
  logic                  Zero_Flag;
  logic                  Overflow_Flag;
  logic                  DivZero_Flag;

  modport master (
    output In_Valid, A, B, ALU_FUN, Out_Ready,
    input  In_Ready, Out_Valid, ALU_OUT, ALU_OUT_HI,
           Zero_Flag, Overflow_Flag, DivZero_Flag
  );

  modport slave (
    input  In_Valid, A, B, ALU_FUN, Out_Ready,
    output In_Ready, Out_Valid, ALU_OUT, ALU_OUT_HI,
           Zero_Flag, Overflow_Flag, DivZero_Flag
  );

endinterface

// File: rtl/alu_seq_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) core. One
// iteration per cycle; done_o flags the final iteration and hi_o/lo_o carry its result.
module alu_iter_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  divzero_o
);

  localparam int N     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [N-1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;
  logic [N-1:0]     opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N:0]       sum_s;
  logic [N:0]       shifted_s;
  logic [N:0]       trial_s;
  logic [N-1:0]     hi_step_s;
  logic [N-1:0]     lo_step_s;
  logic             last_s;

  // One iteration: hi:lo is the product accumulator or remainder:quotient pair.
  always_comb begin
    sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    shifted_s = {hi_q, lo_q[N-1]};
    trial_s   = shifted_s - {1'b0, opnd_q};
    if (div_q) begin
      if (!trial_s[N]) begin
        hi_step_s = trial_s[N-1:0];
        lo_step_s = {lo_q[N-2:0], 1'b1};
      end else begin
        hi_step_s = shifted_s[N-1:0];
        lo_step_s = {lo_q[N-2:0], 1'b0};
      end
    end else begin
      hi_step_s = sum_s[N:1];
      lo_step_s = {sum_s[0], lo_q[N-1:1]};
    end
  end

  assign last_s    = busy_q && (cnt_q == CNT_W'(N - 1));
  assign done_o    = last_s;
  assign hi_o      = hi_step_s;
  assign lo_o      = lo_step_s;
  assign divzero_o = div_q && (opnd_q == {N{1'b0}});

  // Load on start, then iterate until the final step has been taken.
  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      busy_d = 1'b1;
      div_d  = mode_i;
      hi_d   = {N{1'b0}};
      lo_d   = mode_i ? a_i : b_i;
      opnd_d = mode_i ? b_i : a_i;
      cnt_d  = {CNT_W{1'b0}};
    end else if (busy_q) begin
      hi_d   = hi_step_s;
      lo_d   = lo_step_s;
      cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      busy_d = !last_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      hi_q   <= {N{1'b0}};
      lo_q   <= {N{1'b0}};
      opnd_q <= {N{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Handshaked execution unit: one-cycle logic/arith/shift ops plus iterative
// MULU/DIVU, with all results and flags held in output registers.
module alu_seq_muldiv
  import alu_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FUN_WIDTH  = 4
) (
  input logic              CLK,
  input logic              RST,
  alu_seq_muldiv_if.slave  bus
);

  localparam int N       = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  state_e       state_q, state_d;
  logic [N-1:0] out_q, out_d;
  logic [N-1:0] hi_q, hi_d;
  logic         zero_q, zero_d;
  logic         ovf_q, ovf_d;
  logic         dz_q, dz_d;

  logic [3:0]         op_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [N-1:0]       add_s;
  logic [N-1:0]       sub_s;
  logic [N-1:0]       sc_out_s;
  logic               sc_ovf_s;
  logic               start_s;
  logic               core_done_s;
  logic [N-1:0]       core_hi_s;
  logic [N-1:0]       core_lo_s;
  logic               core_dz_s;

  assign op_s    = bus.ALU_FUN[3:0];
  assign shamt_s = bus.B[SHAMT_W-1:0];

  alu_iter_muldiv #(.DATA_WIDTH(N)) u_iter (
    .clk       (CLK),
    .rst       (RST),
    .start_i   (start_s),
    .mode_i    (op_s == ALU_DIVU),
    .a_i       (bus.A),
    .b_i       (bus.B),
    .done_o    (core_done_s),
    .hi_o      (core_hi_s),
    .lo_o      (core_lo_s),
    .divzero_o (core_dz_s)
  );

  // One-cycle datapath evaluated on the live operands at the accept edge.
  always_comb begin
    add_s    = bus.A + bus.B;
    sub_s    = bus.A - bus.B;
    sc_out_s = {N{1'b0}};
    sc_ovf_s = 1'b0;
    case (op_s)
      ALU_AND:  sc_out_s = bus.A & bus.B;
      ALU_OR:   sc_out_s = bus.A | bus.B;
      ALU_XOR:  sc_out_s = bus.A ^ bus.B;
      ALU_NOR:  sc_out_s = ~(bus.A | bus.B);
      ALU_ADD: begin
        sc_out_s = add_s;
        sc_ovf_s = (bus.A[N-1] == bus.B[N-1]) && (add_s[N-1] != bus.A[N-1]);
      end
      ALU_SUB: begin
        sc_out_s = sub_s;
        sc_ovf_s = (bus.A[N-1] != bus.B[N-1]) && (sub_s[N-1] != bus.A[N-1]);
      end
      ALU_SLT:  sc_out_s = {{(N-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ALU_SLTU: sc_out_s = {{(N-1){1'b0}}, (bus.A < bus.B)};
      ALU_SLL:  sc_out_s = bus.A << shamt_s;
      ALU_SRL:  sc_out_s = bus.A >> shamt_s;
      ALU_SRA:  sc_out_s = $signed(bus.A) >>> shamt_s;
      default:  sc_out_s = {N{1'b0}};
    endcase
  end

  // FSM next state and output register loads; DONE ignores In_Valid entirely.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.In_Valid) begin
          if (is_iterative(op_s)) begin
            start_s = 1'b1;
            state_d = BUSY;
          end else begin
            out_d   = sc_out_s;
            hi_d    = {N{1'b0}};
            zero_d  = (sc_out_s == {N{1'b0}});
            ovf_d   = sc_ovf_s;
            dz_d    = 1'b0;
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (core_done_s) begin
          out_d   = core_lo_s;
          hi_d    = core_hi_s;
          zero_d  = (core_lo_s == {N{1'b0}});
          ovf_d   = 1'b0;
          dz_d    = core_dz_s;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (bus.Out_Ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset drops any in-flight operation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      out_q   <= {N{1'b0}};
      hi_q    <= {N{1'b0}};
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.In_Ready      = (state_q == IDLE);
  assign bus.Out_Valid     = (state_q == DONE);
  assign bus.ALU_OUT       = out_q;
  assign bus.ALU_OUT_HI    = hi_q;
  assign bus.Zero_Flag     = zero_q;
  assign bus.Overflow_Flag = ovf_q;
  assign bus.DivZero_Flag  = dz_q;

endmodule
